pri_dec_2to4_seq: RTL and testbench

Sequenced 2-to-4 decoder: the return path for the 4-to-2 priority encoder. It accepts an encoded index and a valid flag from an encoder stage, decodes the index to a one-hot line, and drives that line for a fixed number of cycles followed by a guard gap. A valid/ready handshake back-pressures the source, so a downstream consumer sees one clean, stretched strobe per accepted index.

---
 rtl/pri_pkg.sv | 16 +
 rtl/pri_dec_cnt.sv | 37 +++
 rtl/pri_dec_2to4_seq.sv | 121 ++++++++++++
 tb/tb_pri_dec_2to4_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pri_pkg.sv
// Shared types and helpers for the priority encoder/decoder pair.
package pri_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/pri_dec_cnt.sv
// Loadable down-counter that saturates at zero instead of wrapping.
module pri_dec_cnt
  import pri_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pri_dec_2to4_seq.sv
// Sequenced 2-to-4 decoder: stretched one-hot strobe per accepted index, then a guard gap.
// Optional sticky overrun flag is built when PRI_DEC_OVERRUN_EN is defined.
module pri_dec_2to4_seq
  import pri_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned GAP_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [1:0] a,
  output logic       ready,
  output logic [3:0] y,
  output logic       busy,
  output logic       done
`ifdef PRI_DEC_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYC == 0) ? '0 : CNT_W'(GAP_CYC - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       y_q, y_d;
  logic             done_q, done_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  pri_dec_cnt u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  // y_d follows state_d so the strobe comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    y_d          = 4'b0000;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = HOLD_LD;
    case (state_q)
      IDLE: begin
        if (valid) begin
          idx_d        = a;
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
          y_d          = onehot4(a);
          state_d      = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_zero) begin
          done_d = 1'b1;
          if (GAP_CYC == 0) begin
            state_d = IDLE;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LD;
            state_d      = GAP;
          end
        end else begin
          cnt_dec = 1'b1;
          y_d     = onehot4(idx_q);
        end
      end
      GAP: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      y_q     <= 4'b0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == DRIVE) || (state_q == GAP);
  assign y     = y_q;
  assign done  = done_q;

`ifdef PRI_DEC_OVERRUN_EN
  logic overrun_q;

  // Sticky: flags a source that swapped its index while we were not ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (valid && !ready && (a != idx_q)) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_pri_dec_2to4_seq.sv
// Self-checking bench for pri_dec_2to4_seq: three instances cover the default,
// zero-gap and minimum-hold configurations. Build with PRI_DEC_OVERRUN_EN to check overrun.
`timescale 1ns/1ps
module tb_pri_dec_2to4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] validS;
  logic [1:0] aS [3];
  logic [2:0] readyS, busyS, doneS;
  logic [3:0] yS [3];
`ifdef PRI_DEC_OVERRUN_EN
  logic [2:0] ovS;
`endif

  int testsRun  = 0;
  int failCount = 0;
  int holdOf [3] = '{4, 4, 1};
  int gapOf  [3] = '{1, 0, 0};

  // Free-running 100 MHz clock shared by all instances.
  always #5 clk = ~clk;

  pri_dec_2to4_seq #(.HOLD_CYC(4), .GAP_CYC(1)) dut0 (
    .clk(clk), .rst(rst), .valid(validS[0]), .a(aS[0]), .ready(readyS[0]),
    .y(yS[0]), .busy(busyS[0]), .done(doneS[0])
`ifdef PRI_DEC_OVERRUN_EN
    , .overrun(ovS[0])
`endif
  );

  pri_dec_2to4_seq #(.HOLD_CYC(4), .GAP_CYC(0)) dut1 (
    .clk(clk), .rst(rst), .valid(validS[1]), .a(aS[1]), .ready(readyS[1]),
    .y(yS[1]), .busy(busyS[1]), .done(doneS[1])
`ifdef PRI_DEC_OVERRUN_EN
    , .overrun(ovS[1])
`endif
  );

  pri_dec_2to4_seq #(.HOLD_CYC(1), .GAP_CYC(0)) dut2 (
    .clk(clk), .rst(rst), .valid(validS[2]), .a(aS[2]), .ready(readyS[2]),
    .y(yS[2]), .busy(busyS[2]), .done(doneS[2])
`ifdef PRI_DEC_OVERRUN_EN
    , .overrun(ovS[2])
`endif
  );

  function automatic logic [3:0] expLine(input logic [1:0] idx);
    case (idx)
      2'd0:    expLine = 4'b0001;
      2'd1:    expLine = 4'b0010;
      2'd2:    expLine = 4'b0100;
      default: expLine = 4'b1000;
    endcase
  endfunction

  // Drives a stream of indices into instance s as a well-behaved source (new index
  // only while ready) and scoreboards {y,ready,busy,done} one entry per cycle.
  task automatic applyStimulus(input int s, input logic [1:0] idxs[$], input string tag);
    logic [6:0] expQ[$];
    logic [6:0] e;
    int k = 0;
    int budget = 0;
    int h = holdOf[s];
    int g = gapOf[s];
    aS[s] = idxs[0];
    validS[s] = 1'b1;
    for (int i = 0; i < h; i++) expQ.push_back({expLine(idxs[0]), 3'b010});
    for (int i = 0; i < g; i++) expQ.push_back({4'b0000, 2'b01, (i == 0)});
    expQ.push_back({4'b0000, 2'b10, (g == 0)});
    k = 1;
    while (expQ.size() > 0 && budget < 2000) begin
      @(posedge clk);
      @(negedge clk);
      budget++;
      e = expQ.pop_front();
      testsRun++;
      if (yS[s] !== e[6:3]) begin
        failCount++;
        $display("[TB] FAIL %s y: got %b, expected %b", tag, yS[s], e[6:3]);
      end
      testsRun++;
      if (readyS[s] !== e[2]) begin
        failCount++;
        $display("[TB] FAIL %s ready: got %b, expected %b", tag, readyS[s], e[2]);
      end
      testsRun++;
      if (busyS[s] !== e[1]) begin
        failCount++;
        $display("[TB] FAIL %s busy: got %b, expected %b", tag, busyS[s], e[1]);
      end
      testsRun++;
      if (doneS[s] !== e[0]) begin
        failCount++;
        $display("[TB] FAIL %s done: got %b, expected %b", tag, doneS[s], e[0]);
      end
`ifdef PRI_DEC_OVERRUN_EN
      testsRun++;
      if (ovS[s] !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL %s overrun: got %b, expected 0", tag, ovS[s]);
      end
`endif
      if (readyS[s] === 1'b1) begin
        if (k < idxs.size()) begin
          aS[s] = idxs[k];
          for (int i = 0; i < h; i++) expQ.push_back({expLine(idxs[k]), 3'b010});
          for (int i = 0; i < g; i++) expQ.push_back({4'b0000, 2'b01, (i == 0)});
          expQ.push_back({4'b0000, 2'b10, (g == 0)});
          k++;
        end else begin
          validS[s] = 1'b0;
        end
      end
    end
    validS[s] = 1'b0;
    testsRun++;
    if (k != idxs.size() || expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL %s accepted: got %0d pending %0d, expected %0d pending 0",
               tag, k, expQ.size(), idxs.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    validS = 3'b000;
    for (int s = 0; s < 3; s++) aS[s] = 2'd0;
    #12;
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      testsRun++;
      if (yS[s] !== 4'b0000 || busyS[s] !== 1'b0 || doneS[s] !== 1'b0 || readyS[s] !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL reset dut%0d: got y=%b busy=%b done=%b ready=%b, expected 0000 0 0 1",
                 s, yS[s], busyS[s], doneS[s], readyS[s]);
      end
`ifdef PRI_DEC_OVERRUN_EN
      testsRun++;
      if (ovS[s] !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL reset overrun dut%0d: got %b, expected 0", s, ovS[s]);
      end
`endif
    end
  endtask

  task automatic test_single();
    logic [1:0] q[$];
    q.push_back(2'd2);
    applyStimulus(0, q, "single");
  endtask

  task automatic test_back_to_back();
    logic [1:0] q[$];
    q.push_back(2'd3); q.push_back(2'd0); q.push_back(2'd1); q.push_back(2'd2);
    applyStimulus(1, q, "back_to_back");
  endtask

  task automatic test_min_hold();
    logic [1:0] q[$];
    q.push_back(2'd0); q.push_back(2'd3); q.push_back(2'd2);
    applyStimulus(2, q, "min_hold");
  endtask

  task automatic test_a_toggle();
    aS[0] = 2'd1;
    validS[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      testsRun++;
      if (yS[0] !== 4'b0010) begin
        failCount++;
        $display("[TB] FAIL toggle y cycle %0d: got %b, expected 0010", c, yS[0]);
      end
`ifdef PRI_DEC_OVERRUN_EN
      if (c > 0) begin
        testsRun++;
        if (ovS[0] !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL toggle overrun cycle %0d: got %b, expected 1", c, ovS[0]);
        end
      end
`endif
      aS[0] = 2'd3;
    end
    validS[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (yS[0] !== 4'b0000 || doneS[0] !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL toggle gap: got y=%b done=%b, expected 0000 1", yS[0], doneS[0]);
    end
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (readyS[0] !== 1'b1 || doneS[0] !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL toggle idle: got ready=%b done=%b, expected 1 0", readyS[0], doneS[0]);
    end
`ifdef PRI_DEC_OVERRUN_EN
    testsRun++;
    if (ovS[0] !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL toggle overrun sticky: got %b, expected 1", ovS[0]);
    end
`endif
    rst = 1'b1;
    #1;
`ifdef PRI_DEC_OVERRUN_EN
    testsRun++;
    if (ovS[0] !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL toggle overrun clear: got %b, expected 0", ovS[0]);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [1:0] q[$];
    aS[0] = 2'd1;
    validS[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (yS[0] !== 4'b0010) begin
      failCount++;
      $display("[TB] FAIL mid_reset drive: got %b, expected 0010", yS[0]);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    testsRun++;
    if (yS[0] !== 4'b0000 || busyS[0] !== 1'b0 || doneS[0] !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL mid_reset async: got y=%b busy=%b done=%b, expected 0000 0 0",
               yS[0], busyS[0], doneS[0]);
    end
    validS[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    testsRun++;
    if (readyS[0] !== 1'b1 || yS[0] !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL mid_reset release: got ready=%b y=%b, expected 1 0000", readyS[0], yS[0]);
    end
    q.push_back(2'd3);
    applyStimulus(0, q, "mid_reset_next");
  endtask

  task automatic test_idle();
    validS = 3'b000;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        testsRun++;
        if (yS[s] !== 4'b0000 || doneS[s] !== 1'b0 || readyS[s] !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL idle dut%0d cycle %0d: got y=%b done=%b ready=%b, expected 0000 0 1",
                   s, c, yS[s], doneS[s], readyS[s]);
        end
      end
    end
  endtask

  // Hard stop in case something wedges the sequence.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenarios run back to back; each leaves every instance idle.
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_min_hold();
    test_a_toggle();
    test_mid_reset();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
